// File: rtl/sequential_full_subtractor_wide_if.sv
// Operand/result handshake bundle for the chunked wide subtractor.
// master drives operands and result-ready; slave is the subtractor.
interface sequential_full_subtractor_wide_if #(
    parameter int WIDTH = 1024
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             borrow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, borrow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s, borrow
    );
endinterface

// File: rtl/sequential_full_subtractor_wide.sv
// Multi-cycle s = a - b, one CHUNK-bit slice per cycle, borrow registered.
// Define COND_SUB_EN to return a unchanged whenever a < b.
module sequential_full_subtractor_wide #(
    parameter int WIDTH = 1024,
    parameter int CHUNK = 128
) (
    input logic                          clk,
    input logic                          reset_n,
    sequential_full_subtractor_wide_if.slave io
);
    localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PAD        = NUM_CHUNKS * CHUNK;
    localparam int KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [KW-1:0]    k_q;
    logic             borrow_q;
    logic [PAD-1:0]   a_q;
    logic [PAD-1:0]   b_q;
    logic [PAD-1:0]   res_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] diff;
    logic             chunk_borrow;
    logic             accept;
    logic             release_out;
    logic             last_chunk;

    assign accept      = io.in_valid && in_ready_q;
    assign release_out = out_valid_q && io.out_ready;
    assign last_chunk  = (k_q == K_LAST);

    assign a_chunk = a_q[k_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[k_q*CHUNK +: CHUNK];

    // Extra top bit of the (CHUNK+1)-bit difference is the chunk borrow.
    assign {chunk_borrow, diff} = {1'b0, a_chunk}
                                - {1'b0, b_chunk}
                                - {{CHUNK{1'b0}}, borrow_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)      state_d = RUN;
            RUN:  if (last_chunk)  state_d = DONE;
            DONE: if (release_out) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from next state, so they are 0 in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
        end else if (accept) begin
            a_q      <= PAD'(io.a);
            b_q      <= PAD'(io.b);
            borrow_q <= 1'b0;
            k_q      <= '0;
        end else if (state_q == RUN) begin
            res_q[k_q*CHUNK +: CHUNK] <= diff;
            borrow_q                  <= chunk_borrow;
            k_q <= last_chunk ? '0 : k_q + 1'b1;
        end
    end

    generate
        if (PAD > WIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^res_q[PAD-1:WIDTH];
        end
    endgenerate

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.borrow    = borrow_q;

`ifdef COND_SUB_EN
    assign io.s = borrow_q ? a_q[WIDTH-1:0] : res_q[WIDTH-1:0];
`else
    assign io.s = res_q[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_sequential_full_subtractor_wide.sv
// Directed bench for the chunked wide subtractor, default and 1000-bit builds.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sequential_full_subtractor_wide;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    sequential_full_subtractor_wide_if #(.WIDTH(1024)) io ();
    sequential_full_subtractor_wide_if #(.WIDTH(1000)) io_nm ();

    sequential_full_subtractor_wide #(.WIDTH(1024), .CHUNK(128)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .io     (io.slave)
    );

    sequential_full_subtractor_wide #(.WIDTH(1000), .CHUNK(128)) dut_nm (
        .clk    (clk),
        .reset_n(reset_n),
        .io     (io_nm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [1023:0] got,
                       input logic [1023:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h..%h exp=%h..%h", tag,
                     got[1023:896], got[127:0],
                     exp[1023:896], exp[127:0]);
        end
    endtask

    task automatic run(input string tag,
                       input logic [1023:0] av,
                       input logic [1023:0] bv,
                       input logic [1023:0] es,
                       input logic eb);
        int n;
        n = 0;
        while (!io.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".rdy"}, io.in_ready, 1);
        io.a        = av;
        io.b        = bv;
        io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        chk({tag, ".busy"}, io.in_ready, 0);
        n = 0;
        while (!io.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, n, 8);
        chk({tag, ".s"}, io.s, es);
        chk({tag, ".borrow"}, io.borrow, eb);
    endtask

    task automatic drain(input string tag);
        io.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".ov_drop"}, io.out_valid, 0);
        chk({tag, ".ir_rise"}, io.in_ready, 1);
        io.out_ready = 1'b0;
    endtask

    logic [1023:0] ones;
    logic [1023:0] p128;
    logic [1023:0] exp_s;
    logic [999:0]  exp_nm;
    int            n;

    initial begin
        total = 0;
        bad   = 0;
        ones  = '1;
        p128  = '0;
        p128[128] = 1'b1;

        reset_n         = 1'b0;
        io.in_valid     = 1'b0;
        io.a            = '0;
        io.b            = '0;
        io.out_ready    = 1'b0;
        io_nm.in_valid  = 1'b0;
        io_nm.a         = '0;
        io_nm.b         = '0;
        io_nm.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.in_ready", io.in_ready, 0);
        chk("rst.out_valid", io.out_valid, 0);
        chk("rst.s", io.s, 0);
        chk("rst.borrow", io.borrow, 0);
        reset_n = 1'b1;
        #1;
        chk("rel.in_ready_low", io.in_ready, 0);
        @(negedge clk);
        chk("rel.in_ready_up", io.in_ready, 1);

        run("5m3", 1024'd5, 1024'd3, 1024'd2, 1'b0);
        drain("5m3");

`ifdef COND_SUB_EN
        exp_s = 1024'd3;
`else
        exp_s = ones - 1024'd1;
`endif
        run("3m5", 1024'd3, 1024'd5, exp_s, 1'b1);
        drain("3m5");

        run("xchunk", p128, 1024'd1, p128 - 1024'd1, 1'b0);
        drain("xchunk");

        run("allones", ones, 1024'd0, ones, 1'b0);
        drain("allones");

`ifdef COND_SUB_EN
        exp_s = 1024'd0;
`else
        exp_s = 1024'd1;
`endif
        run("0mmax", 1024'd0, ones, exp_s, 1'b1);
        drain("0mmax");

        run("bp", 1024'd5, 1024'd3, 1024'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            io.in_valid = 1'b1;
            io.a        = 1024'($urandom);
            io.b        = 1024'($urandom);
            @(negedge clk);
            chk("bp.s", io.s, 1024'd2);
            chk("bp.borrow", io.borrow, 0);
            chk("bp.in_ready", io.in_ready, 0);
            chk("bp.out_valid", io.out_valid, 1);
        end
        io.in_valid = 1'b0;
        drain("bp");
        @(negedge clk);
        chk("bp.idle_hold", io.in_ready, 1);

        io.a        = 1024'd9;
        io.b        = 1024'd4;
        io.in_valid = 1'b1;
        @(negedge clk);
        io.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort.in_ready", io.in_ready, 0);
        chk("abort.out_valid", io.out_valid, 0);
        chk("abort.s", io.s, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort.in_ready_up", io.in_ready, 1);
        run("7m7", 1024'd7, 1024'd7, 1024'd0, 1'b0);
        drain("7m7");

`ifdef COND_SUB_EN
        exp_nm = '0;
`else
        exp_nm = '1;
`endif
        n = 0;
        while (!io_nm.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("nm.rdy", io_nm.in_ready, 1);
        io_nm.a        = '0;
        io_nm.b        = 1000'd1;
        io_nm.in_valid = 1'b1;
        @(negedge clk);
        io_nm.in_valid = 1'b0;
        n = 0;
        while (!io_nm.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("nm.lat", n, 8);
        chk("nm.s", 1024'(io_nm.s), 1024'(exp_nm));
        chk("nm.borrow", io_nm.borrow, 1);
        io_nm.out_ready = 1'b1;
        @(negedge clk);
        chk("nm.ir_rise", io_nm.in_ready, 1);
        io_nm.out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sequential_full_subtractor_wide.md
# sequential_full_subtractor_wide

Multi-cycle wide subtractor computing s = a − b over WIDTH bits, CHUNK bits per cycle, with a registered borrow chained between cycles. It is the subtract counterpart of the wide adder and performs the final correction step of the Montgomery modular-square datapath. With the correction option compiled in, it produces the conditional result (a ≥ b ? a − b : a). Operands arrive and results leave on valid/ready handshakes.

## Interface
- WIDTH, 1024, operand/result width in bits.
- CHUNK, 128, bits subtracted per cycle; NUM_CHUNKS = ceil(WIDTH/CHUNK), internal operands zero-padded to NUM_CHUNKS*CHUNK.
- clk  input  1  sole clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block accepts operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  result.
- borrow  output  1  final borrow out (1 iff a < b unsigned).

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE: in_ready=1. On in_valid && in_ready, capture a, b zero-padded into registers, clear borrow_r and chunk counter k. Go to RUN.
- RUN: each cycle, diff[k] = a[k] − b[k] − borrow_r over CHUNK bits, with chunk k = bits [k*CHUNK +: CHUNK]. Store diff[k] in the result register and update borrow_r from the chunk borrow-out. k increments. After k = NUM_CHUNKS−1, go to DONE.
- DONE: out_valid=1. s and borrow are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- Output width rules:
  - s = low WIDTH bits of the padded result.
  - borrow = borrow_r after the last chunk.
  - Zero padding guarantees that borrow equals the WIDTH-bit unsigned borrow.
- Handshake discipline:
  - in_ready=0 in RUN and DONE; in_valid is ignored there and a/b changes have no effect.
  - No overlap of operations.
- in_valid and out_ready are never required to be high in the same state; the handshakes are independent.
- Reset mid-operation (any state): immediate abort. The in-flight result is discarded and the block returns to IDLE.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, s=0, borrow=0, k=0, borrow_r=0.
  - in_ready is a register. It rises on the first clk edge after reset_n deasserts.
- Latency:
  - Accept at edge E0.
  - RUN occupies edges E1..E_NUM_CHUNKS.
  - out_valid=1 after edge E_NUM_CHUNKS (NUM_CHUNKS cycles after accept; 8 for defaults).
- If out_ready=1 while out_valid=1, then after the next edge: out_valid=0 and in_ready=1.
- Minimum issue interval: NUM_CHUNKS+2 cycles.
- Critical path: one CHUNK-bit subtract plus borrow mux. The result register updates one chunk per cycle; no WIDTH-wide carry chain.

## Configuration
- Macro: COND_SUB_EN.
- Defined:
  - s = borrow ? a_captured : (a − b) mod 2^WIDTH, selected by a combinational mux from the captured a and the result register.
  - No added latency.
  - borrow is still reported.
- Undefined:
  - s = (a − b) mod 2^WIDTH, always.
  - The captured-a mux is removed. The a register is still needed for RUN.

## Test plan
- WIDTH=1024, CHUNK=128, a=5, b=3 -> s=2, borrow=0, out_valid exactly 8 cycles after accept.
- a=3, b=5 -> without COND_SUB_EN: s=2^1024−2, borrow=1. With COND_SUB_EN: s=3, borrow=1.
- Cross-chunk borrow: a=2^128, b=1 -> s=2^128−1, borrow=0. Also a=2^1024−1, b=0 -> s=a, borrow=0.
- Backpressure: out_ready=0 for 10 cycles in DONE, with in_valid=1 and changing a/b -> s and borrow stable, in_ready=0, no new accept. Then out_ready=1 -> in_ready=1 next cycle.
- Reset during RUN at k=3 -> out_valid and in_ready drop to 0 immediately. After release, a=7, b=7 -> s=0, borrow=0.
- Non-multiple width, WIDTH=1000, CHUNK=128, a=0, b=1 -> s=2^1000−1 (without COND_SUB_EN), borrow=1, latency 8.
